// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 4-bank Stockham FFT memory.
// Default geometry: N = 2^FFT_NUMSTAGES points, A-bit bank addresses.
package fft_pkg;

  localparam int FFT_NUMSTAGES = 5;
  localparam int N = 1 << FFT_NUMSTAGES;
  localparam int A = FFT_NUMSTAGES - 2;

  // Write-source select for the bank write crossbar
  typedef enum logic [1:0] {
    M1_DIRECT = 2'b00,
    M1_SWAP   = 2'b01,
    M1_LOAD   = 2'b10
  } m1_sel_e;

  // Bank holding data index n: {n[MSB] ^ n[1], n[0]}
  function automatic logic [1:0] bank_of(input logic [FFT_NUMSTAGES-1:0] n);
    return {n[FFT_NUMSTAGES-1] ^ n[1], n[0]};
  endfunction

endpackage

// File: rtl/fft_addr_mux_gen_if.sv
// Controller <-> address/mux generator bundle.
// Optional stage_done signal present when STAGE_DONE_EN is defined.
interface fft_addr_mux_gen_if #(
  parameter int AW = 3
);

  logic          en;
  logic          ld_data;
  logic [AW-1:0] counter;
  logic [2:0]    stage_num;

  logic [AW-1:0] rd_addr0;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [AW-1:0] rd_addr3;
  logic [AW-1:0] wr_addr0;
  logic [AW-1:0] wr_addr1;
  logic [AW-1:0] wr_addr2;
  logic [AW-1:0] wr_addr3;
  logic          wr_en;
  logic          m0_s;
  logic [1:0]    m1_s;
  logic          m2_s;
  logic          m3_s;
`ifdef STAGE_DONE_EN
  logic          stage_done;
`endif

  // Stage controller side
  modport master (
    output en, ld_data, counter, stage_num,
    input
`ifdef STAGE_DONE_EN
          stage_done,
`endif
          rd_addr0, rd_addr1, rd_addr2, rd_addr3,
          wr_addr0, wr_addr1, wr_addr2, wr_addr3,
          wr_en, m0_s, m1_s, m2_s, m3_s
  );

  // Address/mux generator side
  modport slave (
    input  en, ld_data, counter, stage_num,
    output
`ifdef STAGE_DONE_EN
          stage_done,
`endif
          rd_addr0, rd_addr1, rd_addr2, rd_addr3,
          wr_addr0, wr_addr1, wr_addr2, wr_addr3,
          wr_en, m0_s, m1_s, m2_s, m3_s
  );

endinterface

// File: rtl/fft_wr_delay.sv
// Delay line carrying the cycle counter and write-valid from read issue
// to write-back. Shifts every cycle so in-flight writes drain after en falls.
module fft_wr_delay #(
  parameter int AW    = 3,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cnt_i,
  input  logic          vld_i,
  output logic [AW-1:0] dc_o,
  output logic          dv_o
);

  logic [DEPTH-1:0][AW-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]         vld_q, vld_d;

  // Next contents: new sample enters stage 0, everything else moves one up
  always_comb begin
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    cnt_d[0] = cnt_i;
    vld_d[0] = vld_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      cnt_d[i] = cnt_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
  end

  // Shift register; reset discards pending writes
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign dc_o = cnt_q[DEPTH-1];
  assign dv_o = vld_q[DEPTH-1];

endmodule

// File: rtl/fft_addr_mux_gen.sv
// Registered read/write address and crossbar-select generator for the
// 4-bank radix-2 constant-geometry FFT memory.
// Optional feature macro: STAGE_DONE_EN (adds stage_done pulse output).
module fft_addr_mux_gen
  import fft_pkg::*;
#(
  parameter int NUMSTAGES = FFT_NUMSTAGES,
  parameter int WR_LAT    = 2
) (
  input logic               clk,
  input logic               rst,
  fft_addr_mux_gen_if.slave bus
);

  localparam int         AW         = NUMSTAGES - 2;
  localparam logic [2:0] LAST_STAGE = 3'(NUMSTAGES - 1);

  // Banks 0/1 share one read address, banks 2/3 the other
  logic [AW-1:0] rd_lo_q, rd_lo_d;
  logic [AW-1:0] rd_hi_q, rd_hi_d;
  logic          m0_s_q, m0_s_d;

  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          wr_en_q, wr_en_d;
  m1_sel_e       m1_s_q, m1_s_d;

  logic          m2_s_q, m2_s_d;
  logic          m3_s_q, m3_s_d;

  logic [AW-1:0] dc;
  logic          dv;
  logic          load;

  assign load = bus.en & bus.ld_data;

  fft_wr_delay #(
    .AW    (AW),
    .DEPTH (WR_LAT)
  ) u_wr_delay (
    .clk   (clk),
    .rst   (rst),
    .cnt_i (bus.counter),
    .vld_i (bus.en & ~bus.ld_data),
    .dc_o  (dc),
    .dv_o  (dv)
  );

  // Read mapping: tops 2c,2c+1 and bottoms 2c+N/2,2c+N/2+1 at bank addresses
  always_comb begin
    rd_lo_d = '0;
    rd_hi_d = '0;
    m0_s_d  = 1'b0;
    if (bus.en) begin
      rd_lo_d = {bus.counter[0], bus.counter[AW-1:1]};
      rd_hi_d = {~bus.counter[0], bus.counter[AW-1:1]};
      m0_s_d  = bus.counter[0];
    end
  end

  // Write select: a load cycle overrides (and drops) a delayed butterfly write
  always_comb begin
    wr_addr_d = dc;
    wr_en_d   = dv;
    m1_s_d    = dc[AW-1] ? M1_SWAP : M1_DIRECT;
    if (load) begin
      wr_addr_d = bus.counter;
      wr_en_d   = 1'b1;
      m1_s_d    = M1_LOAD;
    end
  end

  // Stage flags; out-of-range stage numbers simply match neither compare
  always_comb begin
    m2_s_d = bus.en & (bus.stage_num == LAST_STAGE);
    m3_s_d = bus.en & ~bus.ld_data & (bus.stage_num == 3'd0);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_lo_q   <= '0;
      rd_hi_q   <= '0;
      m0_s_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      m1_s_q    <= M1_DIRECT;
      m2_s_q    <= 1'b0;
      m3_s_q    <= 1'b0;
    end else begin
      rd_lo_q   <= rd_lo_d;
      rd_hi_q   <= rd_hi_d;
      m0_s_q    <= m0_s_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      m1_s_q    <= m1_s_d;
      m2_s_q    <= m2_s_d;
      m3_s_q    <= m3_s_d;
    end
  end

  assign bus.rd_addr0 = rd_lo_q;
  assign bus.rd_addr1 = rd_lo_q;
  assign bus.rd_addr2 = rd_hi_q;
  assign bus.rd_addr3 = rd_hi_q;
  assign bus.wr_addr0 = wr_addr_q;
  assign bus.wr_addr1 = wr_addr_q;
  assign bus.wr_addr2 = wr_addr_q;
  assign bus.wr_addr3 = wr_addr_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.m0_s     = m0_s_q;
  assign bus.m1_s     = m1_s_q;
  assign bus.m2_s     = m2_s_q;
  assign bus.m3_s     = m3_s_q;

`ifdef STAGE_DONE_EN
  logic stage_done_q, stage_done_d;

  // Pulse alongside the final butterfly write of a stage
  always_comb begin
    stage_done_d = ~load & dv & (dc == '1);
  end

  // Stage-done register
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_done_q <= 1'b0;
    end else begin
      stage_done_q <= stage_done_d;
    end
  end

  assign bus.stage_done = stage_done_q;
`endif

endmodule

// File: tb/tb_fft_addr_mux_gen.sv
// Self-checking bench for fft_addr_mux_gen (NUMSTAGES=5, WR_LAT=2).
// Reference model works from data indices and bank placement.
// Honours STAGE_DONE_EN when defined.
module tb_fft_addr_mux_gen;

  localparam int NS     = 5;
  localparam int NPTS   = 1 << NS;
  localparam int WR_LAT = 2;
  localparam int MAXE   = 4096;

  typedef struct {
    bit rst;
    bit en;
    bit ld;
    int cnt;
    int stg;
  } stim_t;

  logic clk = 1'b0;
  logic rst;

  fft_addr_mux_gen_if #(.AW(NS - 2)) bus ();

  fft_addr_mux_gen #(
    .NUMSTAGES (NS),
    .WR_LAT    (WR_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    eidx  = -1;
  int    last_rst = -1;
  stim_t hist [MAXE];

  // Bank of data index n: {n[NS-1] xor n[1], n[0]}
  function automatic int tb_bank(input int n);
    return (((n >> (NS - 1)) ^ (n >> 1)) & 1) * 2 + (n & 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, eidx, obs, exp);
    end
  endtask

  // Compare every output against the model for the latest edge
  task automatic check_all();
    stim_t s;
    int    e_rd [4];
    int    e_wr [4];
    int    e_m0, e_m1, e_m2, e_m3, e_we, e_sd;
    int    oc;
    bit    ov;
    s = hist[eidx];
    for (int k = 0; k < 4; k++) begin
      e_rd[k] = 0;
      e_wr[k] = 0;
    end
    e_m0 = 0; e_m1 = 0; e_m2 = 0; e_m3 = 0; e_we = 0; e_sd = 0;
    if (!s.rst) begin
      if (s.en) begin
        int idx [4];
        idx[0] = 2 * s.cnt;
        idx[1] = 2 * s.cnt + 1;
        idx[2] = 2 * s.cnt + NPTS / 2;
        idx[3] = 2 * s.cnt + NPTS / 2 + 1;
        for (int k = 0; k < 4; k++) e_rd[tb_bank(idx[k])] = idx[k] / 4;
        e_m0 = (tb_bank(idx[0]) >= 2) ? 1 : 0;
      end
      oc = 0;
      ov = 1'b0;
      if (eidx - WR_LAT > last_rst) begin
        oc = hist[eidx - WR_LAT].cnt;
        ov = hist[eidx - WR_LAT].en && !hist[eidx - WR_LAT].ld;
      end
      if (s.en && s.ld) begin
        for (int k = 0; k < 4; k++) e_wr[k] = s.cnt;
        e_we = 1;
        e_m1 = 2;
      end else begin
        for (int j = 0; j < 4; j++) e_wr[tb_bank(4 * oc + j)] = (4 * oc + j) / 4;
        e_we = ov ? 1 : 0;
        e_m1 = (tb_bank(4 * oc) >= 2) ? 1 : 0;
        e_sd = (ov && oc == NPTS / 4 - 1) ? 1 : 0;
      end
      e_m2 = (s.en && s.stg == NS - 1) ? 1 : 0;
      e_m3 = (s.en && !s.ld && s.stg == 0) ? 1 : 0;
    end
    chk("rd_addr0", 32'(bus.rd_addr0), 32'(e_rd[0]));
    chk("rd_addr1", 32'(bus.rd_addr1), 32'(e_rd[1]));
    chk("rd_addr2", 32'(bus.rd_addr2), 32'(e_rd[2]));
    chk("rd_addr3", 32'(bus.rd_addr3), 32'(e_rd[3]));
    chk("wr_addr0", 32'(bus.wr_addr0), 32'(e_wr[0]));
    chk("wr_addr1", 32'(bus.wr_addr1), 32'(e_wr[1]));
    chk("wr_addr2", 32'(bus.wr_addr2), 32'(e_wr[2]));
    chk("wr_addr3", 32'(bus.wr_addr3), 32'(e_wr[3]));
    chk("wr_en",    32'(bus.wr_en),    32'(e_we));
    chk("m0_s",     32'(bus.m0_s),     32'(e_m0));
    chk("m1_s",     32'(bus.m1_s),     32'(e_m1));
    chk("m2_s",     32'(bus.m2_s),     32'(e_m2));
    chk("m3_s",     32'(bus.m3_s),     32'(e_m3));
`ifdef STAGE_DONE_EN
    chk("stage_done", 32'(bus.stage_done), 32'(e_sd));
`endif
  endtask

  // Drive one cycle of inputs, let the DUT sample them, check afterwards
  task automatic step(input bit r, input bit e, input bit l, input int c, input int s);
    @(negedge clk);
    rst           = r;
    bus.en        = e;
    bus.ld_data   = l;
    bus.counter   = 3'(c);
    bus.stage_num = 3'(s);
    @(posedge clk);
    if (eidx < MAXE - 1) eidx++;
    hist[eidx] = '{rst: r, en: e, ld: l, cnt: c, stg: s};
    if (r) last_rst = eidx;
    #1;
    check_all();
  endtask

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.ld_data   = 1'b0;
    bus.counter   = '0;
    bus.stage_num = '0;

    // Reset for two cycles
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_m1_s",  32'(bus.m1_s),  32'd0);

    // Read mapping directed points
    step(0, 1, 0, 3, 1);
    chk("tp_rd0_c3", 32'(bus.rd_addr0), 32'd5);
    chk("tp_rd2_c3", 32'(bus.rd_addr2), 32'd1);
    chk("tp_m0_c3",  32'(bus.m0_s),     32'd1);
    step(0, 1, 0, 6, 1);
    chk("tp_rd1_c6", 32'(bus.rd_addr1), 32'd3);
    chk("tp_rd3_c6", 32'(bus.rd_addr3), 32'd7);
    chk("tp_m0_c6",  32'(bus.m0_s),     32'd0);

    // Write latency: counter=5 at edge t appears after edge t+2
    step(0, 1, 0, 5, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 1);
    chk("tp_wr0_c5", 32'(bus.wr_addr0), 32'd5);
    chk("tp_we_c5",  32'(bus.wr_en),    32'd1);
    chk("tp_m1_c5",  32'(bus.m1_s),     32'd1);

    // Load mode overrides a pending butterfly write
    step(0, 1, 1, 2, 0);
    chk("tp_ld_wr3", 32'(bus.wr_addr3), 32'd2);
    chk("tp_ld_m1",  32'(bus.m1_s),     32'd2);
    chk("tp_ld_m3",  32'(bus.m3_s),     32'd0);

    // Stage flags
    step(0, 1, 0, 0, 4);
    chk("tp_m2_s4", 32'(bus.m2_s), 32'd1);
    step(0, 1, 0, 0, 0);
    chk("tp_m3_s0", 32'(bus.m3_s), 32'd1);
    step(0, 1, 0, 0, 5);
    chk("tp_m2_s5", 32'(bus.m2_s), 32'd0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Full stages, each followed by the write tail after en drops
    for (int s = 0; s < NS; s++) begin
      for (int c = 0; c < NPTS / 4; c++) step(0, 1, 0, c, s);
      step(0, 0, 0, 0, s);
      chk("tail_rd0", 32'(bus.rd_addr0), 32'd0);
      chk("tail_we1", 32'(bus.wr_en),    32'd1);
      step(0, 0, 0, 0, s);
      chk("tail_we2", 32'(bus.wr_en),    32'd1);
      chk("tail_wa2", 32'(bus.wr_addr0), 32'd7);
`ifdef STAGE_DONE_EN
      chk("tail_done", 32'(bus.stage_done), 32'd1);
`endif
      step(0, 0, 0, 0, s);
      chk("tail_we3", 32'(bus.wr_en), 32'd0);
    end

    // Reset mid-stage discards in-flight writes
    step(0, 1, 0, 4, 2);
    step(0, 1, 0, 5, 2);
    step(1, 1, 0, 6, 2);
    step(0, 0, 0, 0, 2);
    chk("rst_drop1", 32'(bus.wr_en), 32'd0);
    step(0, 0, 0, 0, 2);
    chk("rst_drop2", 32'(bus.wr_en), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
